// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin owner of a WIDTH-bit JK register bank shared by two requesters.
// All state advances on the falling clock edge; clear is asynchronous active-low.
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req_a,
    input  logic [1:0]       cmd_a,
    input  logic [WIDTH-1:0] mask_a,
    input  logic [LEN_W-1:0] len_a,
    input  logic             req_b,
    input  logic [1:0]       cmd_b,
    input  logic [WIDTH-1:0] mask_b,
    input  logic [LEN_W-1:0] len_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic             busy,
    output logic [WIDTH-1:0] q
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_cmd;
    logic [WIDTH-1:0]   r_mask;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_last_b;
    logic [WIDTH-1:0]   r_q;
    logic               r_gnt_a, r_gnt_b, r_done_a, r_done_b;

    logic               w_pick_a, w_pick_b;
    logic [LEN_W-1:0]   w_len_a, w_len_b;
    logic [WIDTH-1:0]   w_cmd_val, w_q_next;

    // On a tie the requester that did not own the bank last wins.
    assign w_pick_a  = req_a & (~req_b | r_last_b);
    assign w_pick_b  = req_b & ~w_pick_a;
    assign w_len_a   = (len_a == '0) ? LEN_W'(1) : len_a;
    assign w_len_b   = (len_b == '0) ? LEN_W'(1) : len_b;
    assign w_cmd_val = (r_cmd == 2'b01) ? '0 :
                       (r_cmd == 2'b10) ? '1 :
                       (r_cmd == 2'b11) ? ~r_q : r_q;
    assign w_q_next  = (r_q & ~r_mask) | (w_cmd_val & r_mask);

    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_last_b <= 1'b1;
            r_q      <= '0;
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_pick_a | w_pick_b) begin
                    r_state  <= EXEC;
                    r_cmd    <= w_pick_a ? cmd_a : cmd_b;
                    r_mask   <= w_pick_a ? mask_a : mask_b;
                    r_cnt    <= w_pick_a ? w_len_a : w_len_b;
                    r_gnt_a  <= w_pick_a;
                    r_gnt_b  <= w_pick_b;
                    r_last_b <= w_pick_b;
                end
                EXEC: begin
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        r_state  <= DONE;
                        r_done_a <= r_gnt_a;
                        r_done_b <= r_gnt_b;
                        r_gnt_a  <= 1'b0;
                        r_gnt_b  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign q      = r_q;
    assign gnt_a  = r_gnt_a;
    assign gnt_b  = r_gnt_b;
    assign done_a = r_done_a;
    assign done_b = r_done_b;
    assign busy   = (r_state != IDLE);
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed vector table plus hand sequences for reset, arbitration and input stability.
module tb_jk_bank_sequencer;
    logic       clk = 1'b1;
    logic       clear = 1'b0;
    logic       req_a = 0, req_b = 0;
    logic [1:0] cmd_a = 0, cmd_b = 0;
    logic [7:0] mask_a = 0, mask_b = 0;
    logic [3:0] len_a = 0, len_b = 0;
    logic       gnt_a, gnt_b, done_a, done_b, busy;
    logic [7:0] q;

    int n_pass = 0;
    int n_total = 0;

    jk_bank_sequencer #(.WIDTH(8), .LEN_W(4)) dut (
        .clk(clk), .clear(clear),
        .req_a(req_a), .cmd_a(cmd_a), .mask_a(mask_a), .len_a(len_a),
        .req_b(req_b), .cmd_b(cmd_b), .mask_b(mask_b), .len_b(len_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .busy(busy), .q(q)
    );

    always #5 clk = ~clk;

    // flags = {gnt_a, gnt_b, done_a, done_b, busy}
    typedef struct {
        logic       ra;
        logic [1:0] ca;
        logic [7:0] ma;
        logic [3:0] la;
        logic       rb;
        logic [1:0] cb;
        logic [7:0] mb;
        logic [3:0] lb;
        logic [7:0] eq;
        logic [4:0] ef;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [7:0] eq, input logic [4:0] ef);
        logic [4:0] af;
        af = {gnt_a, gnt_b, done_a, done_b, busy};
        n_total++;
        if (q === eq && af === ef && !(gnt_a & gnt_b) && !(done_a & done_b)) n_pass++;
        else $display("FAIL %s: got q=%h gnt_a/gnt_b/done_a/done_b/busy=%b, want q=%h flags=%b",
                      nm, q, af, eq, ef);
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #1;
        chk("reset_async", 8'h00, 5'b00000);
        @(posedge clk);
        req_a = 0; req_b = 0;
        clear = 1'b1;
    endtask

    initial begin
        logic [7:0] m;
        vecs[0]  = '{1, 2'b10, 8'hF0, 4'd1, 0, 2'b00, 8'h00, 4'd0, 8'h00, 5'b10001};
        vecs[1]  = '{0, 2'b01, 8'hFF, 4'd5, 0, 2'b00, 8'h00, 4'd0, 8'hF0, 5'b00101};
        vecs[2]  = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'hF0, 5'b00000};
        vecs[3]  = '{0, 2'b00, 8'h00, 4'd0, 1, 2'b01, 8'h30, 4'd0, 8'hF0, 5'b01001};
        vecs[4]  = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b10, 8'hFF, 4'd7, 8'hC0, 5'b00011};
        vecs[5]  = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'hC0, 5'b00000};
        vecs[6]  = '{0, 2'b00, 8'h00, 4'd0, 1, 2'b01, 8'hFF, 4'd1, 8'hC0, 5'b01001};
        vecs[7]  = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h00, 5'b00011};
        vecs[8]  = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h00, 5'b00000};
        vecs[9]  = '{1, 2'b11, 8'h0F, 4'd3, 0, 2'b00, 8'h00, 4'd0, 8'h00, 5'b10001};
        vecs[10] = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h0F, 5'b10001};
        vecs[11] = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h00, 5'b10001};
        vecs[12] = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h0F, 5'b00101};
        vecs[13] = '{0, 2'b00, 8'h00, 4'd0, 0, 2'b00, 8'h00, 4'd0, 8'h0F, 5'b00000};

        // Reset held with random inputs and a running clock
        for (int i = 0; i < 4; i++) begin
            req_a = 1'($urandom); req_b = 1'($urandom);
            cmd_a = 2'($urandom); cmd_b = 2'($urandom);
            mask_a = 8'($urandom); mask_b = 8'($urandom);
            len_a = 4'($urandom); len_b = 4'($urandom);
            edge_step();
            chk($sformatf("reset_hold%0d", i), 8'h00, 5'b00000);
        end
        @(posedge clk);
        req_a = 0; req_b = 0;
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk($sformatf("idle_after_reset%0d", i), 8'h00, 5'b00000);
        end

        for (int i = 0; i < 14; i++) begin
            req_a = vecs[i].ra; cmd_a = vecs[i].ca; mask_a = vecs[i].ma; len_a = vecs[i].la;
            req_b = vecs[i].rb; cmd_b = vecs[i].cb; mask_b = vecs[i].mb; len_b = vecs[i].lb;
            edge_step();
            chk($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ef);
        end

        // Both requesters held high from reset: A, B, A, B, three edges each
        do_reset();
        req_a = 1; cmd_a = 2'b11; mask_a = 8'h01; len_a = 4'd1;
        req_b = 1; cmd_b = 2'b11; mask_b = 8'h02; len_b = 4'd1;
        m = 8'h00;
        for (int k = 0; k < 12; k++) begin
            logic own_a;
            own_a = ((k / 3) % 2) == 0;
            edge_step();
            if (k % 3 == 0)
                chk($sformatf("rr_grant%0d", k), m, own_a ? 5'b10001 : 5'b01001);
            else if (k % 3 == 1) begin
                m = m ^ (own_a ? 8'h01 : 8'h02);
                chk($sformatf("rr_done%0d", k), m, own_a ? 5'b00101 : 5'b00011);
            end else
                chk($sformatf("rr_idle%0d", k), m, 5'b00000);
        end

        // Reset in the middle of a long toggle
        do_reset();
        req_a = 1; cmd_a = 2'b11; mask_a = 8'hFF; len_a = 4'd10;
        edge_step();
        chk("mid_grant", 8'h00, 5'b10001);
        req_a = 0;
        for (int i = 1; i <= 4; i++) begin
            edge_step();
            chk($sformatf("mid_e%0d", i), (i % 2) ? 8'hFF : 8'h00, 5'b10001);
        end
        clear = 1'b0;
        #1;
        chk("mid_abort", 8'h00, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk($sformatf("mid_held%0d", i), 8'h00, 5'b00000);
        end
        @(posedge clk);
        clear = 1'b1;
        edge_step();
        chk("mid_no_resume", 8'h00, 5'b00000);

        // Granted requester's inputs change every cycle during EXEC
        req_a = 1; cmd_a = 2'b11; mask_a = 8'h0F; len_a = 4'd4;
        edge_step();
        chk("stab_grant", 8'h00, 5'b10001);
        req_a = 0;
        for (int i = 1; i <= 4; i++) begin
            cmd_a = 2'(i); mask_a = 8'($urandom) | 8'hF0; len_a = 4'($urandom);
            edge_step();
            chk($sformatf("stab_e%0d", i), (i % 2) ? 8'h0F : 8'h00, (i < 4) ? 5'b10001 : 5'b00101);
        end
        edge_step();
        chk("stab_idle", 8'h00, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
